// File: rtl/bingo_pkg.sv
// Shared constants, state encoding and helpers for the bingo board input path.
// Geometry assumes a 640x480 frame with a 5x5 board of 64 px cells.
package bingo_pkg;

    localparam int GRID      = 5;
    localparam int CELLS     = GRID * GRID;
    localparam int NUM_W     = 5;
    localparam int NUM_LINES = 2 * GRID + 2;

    localparam int WIN_X0_DEF     = 160;
    localparam int WIN_Y0_DEF     = 80;
    localparam int CELL_SHIFT_DEF = 6;
    localparam int WIN_LINES_DEF  = 5;

    localparam int ROW0 = 0;
    localparam int ROW1 = 1;
    localparam int ROW2 = 2;
    localparam int ROW3 = 3;
    localparam int ROW4 = 4;
    localparam int COL0 = 5;
    localparam int COL1 = 6;
    localparam int COL2 = 7;
    localparam int COL3 = 8;
    localparam int COL4 = 9;
    localparam int DIAG = 10;
    localparam int ANTI = 11;

    typedef enum logic [2:0] {IDLE, HIT, SCAN, MARK, EVAL} state_t;
    typedef enum logic {SRC_LOCAL, SRC_REMOTE} src_t;

    function automatic logic [NUM_W-1:0] cell_num(input logic [CELLS*NUM_W-1:0] map,
                                                   input logic [4:0] idx);
        return map[int'(idx) * NUM_W +: NUM_W];
    endfunction

endpackage

// File: rtl/bingo_line_eval.sv
// Combinational line detector: which of the 12 rows/columns/diagonals are fully
// circled, plus how many there are.
module bingo_line_eval
    import bingo_pkg::*;
(
    input  logic [CELLS-1:0]     circle,
    output logic [NUM_LINES-1:0] line,
    output logic [3:0]           line_cnt
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        line     = '1;
        line_cnt = '0;
        for (int r = 0; r < GRID; r++) begin
            for (int c = 0; c < GRID; c++) begin
                line[ROW0 + r] = line[ROW0 + r] & circle[r * GRID + c];
                line[COL0 + c] = line[COL0 + c] & circle[r * GRID + c];
            end
            line[DIAG] = line[DIAG] & circle[r * GRID + r];
            line[ANTI] = line[ANTI] & circle[r * GRID + (GRID - 1 - r)];
        end
        for (int i = 0; i < NUM_LINES; i++) begin
            line_cnt = line_cnt + 4'(line[i]);
        end
    end

endmodule

// File: rtl/bingo_mark_ctrl.sv
// Turns local pointer clicks and opponent-called numbers into board marks, and
// keeps the circle bitmap, completed-line flags and sticky bingo flag.
module bingo_mark_ctrl
    import bingo_pkg::*;
#(
    parameter int WIN_X0     = WIN_X0_DEF,
    parameter int WIN_Y0     = WIN_Y0_DEF,
    parameter int CELL_SHIFT = CELL_SHIFT_DEF,
    parameter int WIN_LINES  = WIN_LINES_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [9:0]               ptr_x,
    input  logic [9:0]               ptr_y,
    input  logic                     ptr_valid,
    input  logic                     click,
    input  logic                     my_turn,
    input  logic [CELLS*NUM_W-1:0]   map,
    input  logic                     remote_valid,
    input  logic [NUM_W-1:0]         remote_num,
    output logic                     remote_ready,
    output logic [CELLS-1:0]         circle,
    output logic [NUM_LINES-1:0]     line,
    output logic [3:0]               line_cnt,
    output logic                     bingo,
    output logic                     pick_valid,
    output logic [NUM_W-1:0]         pick_num,
    output logic                     busy
);

    localparam logic [9:0] X_LO = 10'(WIN_X0);
    localparam logic [9:0] X_HI = 10'(WIN_X0 + (GRID << CELL_SHIFT));
    localparam logic [9:0] Y_LO = 10'(WIN_Y0);
    localparam logic [9:0] Y_HI = 10'(WIN_Y0 + (GRID << CELL_SHIFT));

    state_t             state, state_next;
    logic               click_d, click_edge;
    logic [9:0]         x_q, y_q;
    logic [NUM_W-1:0]   num_q;
    logic [4:0]         scan_idx, idx_q;
    src_t               src_q;

    logic [9:0]         dx, dy, bx, by;
    logic               in_win;
    logic [4:0]         hit_idx;
    logic [NUM_W-1:0]   scan_num;

    logic               latch_remote, latch_ptr, scan_step, mark_load;
    logic [4:0]         mark_idx;
    src_t               mark_src;

    logic [NUM_LINES-1:0] line_next;
    logic [3:0]           cnt_next;

    assign click_edge = click & ~click_d;

    // Subtraction stays at pointer width; out-of-window values wrap but are gated by in_win.
    assign dx       = x_q - X_LO;
    assign dy       = y_q - Y_LO;
    assign bx       = dx >> CELL_SHIFT;
    assign by       = dy >> CELL_SHIFT;
    assign hit_idx  = 5'(bx + 10'd5 * by);
    assign in_win   = (x_q >= X_LO) && (x_q < X_HI) && (y_q >= Y_LO) && (y_q < Y_HI);
    assign scan_num = cell_num(map, scan_idx);

    assign remote_ready = (state == IDLE);
    assign busy         = (state != IDLE);

    bingo_line_eval u_line_eval (
        .circle   (circle),
        .line     (line_next),
        .line_cnt (cnt_next)
    );

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next   = state;
        latch_remote = 1'b0;
        latch_ptr    = 1'b0;
        scan_step    = 1'b0;
        mark_load    = 1'b0;
        mark_idx     = idx_q;
        mark_src     = src_q;
        unique case (state)
            IDLE: begin
                if (remote_valid) begin
                    latch_remote = 1'b1;
                    state_next   = SCAN;
                end else if (click_edge && ptr_valid && my_turn) begin
                    latch_ptr  = 1'b1;
                    state_next = HIT;
                end
            end
            HIT: begin
                if (!in_win || circle[hit_idx]) begin
                    state_next = IDLE;
                end else begin
                    mark_load  = 1'b1;
                    mark_idx   = hit_idx;
                    mark_src   = SRC_LOCAL;
                    state_next = MARK;
                end
            end
            SCAN: begin
                if (num_q == '0) begin
                    state_next = IDLE;
                end else if (scan_num == num_q) begin
                    mark_load  = 1'b1;
                    mark_idx   = scan_idx;
                    mark_src   = SRC_REMOTE;
                    state_next = MARK;
                end else if (scan_idx == 5'(CELLS - 1)) begin
                    state_next = IDLE;
                end else begin
                    scan_step = 1'b1;
                end
            end
            MARK:    state_next = EVAL;
            EVAL:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: the 25-bit board is plain flops, so reset clears it along with the rest.
        if (rst) begin
            click_d    <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            num_q      <= '0;
            scan_idx   <= '0;
            idx_q      <= '0;
            src_q      <= SRC_LOCAL;
            circle     <= '0;
            line       <= '0;
            line_cnt   <= '0;
            bingo      <= 1'b0;
            pick_valid <= 1'b0;
            pick_num   <= '0;
        end else begin
            click_d    <= click;
            pick_valid <= 1'b0;
            if (latch_remote) begin
                num_q    <= remote_num;
                scan_idx <= '0;
            end
            if (latch_ptr) begin
                x_q <= ptr_x;
                y_q <= ptr_y;
            end
            if (scan_step) scan_idx <= scan_idx + 5'd1;
            if (mark_load) begin
                idx_q <= mark_idx;
                src_q <= mark_src;
            end
            if (state == MARK) begin
                circle[idx_q] <= 1'b1;
                if (src_q == SRC_LOCAL && !circle[idx_q]) begin
                    pick_valid <= 1'b1;
                    pick_num   <= cell_num(map, idx_q);
                end
            end
            if (state == EVAL) begin
                line     <= line_next;
                line_cnt <= cnt_next;
                if (cnt_next >= 4'(WIN_LINES)) bingo <= 1'b1;
            end
        end
    end

endmodule

// File: doc/bingo_mark_ctrl.md
Name: bingo_mark_ctrl

Overview:
- Input-side counterpart of the VGA board display.
- Maps a pointer click in screen coordinates (640x480 frame, 320x320 board window at x=160..479, y=80..399, 5x5 cells of 64 px) back to a board cell index.
- Also resolves a number called by the opponent board to the cell holding that number.
- Maintains the circle bitmap, the 12 completed-line flags and the bingo flag that the display and game logic consume.

Parameters:
- WIN_X0, 160, left edge of board window (pixels)
- WIN_Y0, 80, top edge of board window (pixels)
- CELL_SHIFT, 6, log2 of cell size in pixels (64)
- GRID, 5, cells per row/column (fixed at 5; other values unsupported)
- WIN_LINES, 5, line count at which bingo asserts

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ptr_x  in  10  pointer x, screen pixels
- ptr_y  in  10  pointer y, screen pixels
- ptr_valid  in  1  pointer coordinates valid
- click  in  1  pointer button level, already debounced
- my_turn  in  1  local picks allowed
- map  in  125  5-bit number per cell; cell i at map[5i+4:5i]; values 1..25
- remote_valid  in  1  opponent number offered
- remote_num  in  5  opponent number
- remote_ready  out  1  high when in IDLE; transfer on remote_valid & remote_ready
- circle  out  25  marked cells, bit i = cell i (i = x + 5y)
- line  out  12  completed lines: [4:0] rows 0..4, [9:5] cols 0..4, [10] diag 0,6,12,18,24, [11] anti-diag 4,8,12,16,20
- line_cnt  out  4  popcount of line
- bingo  out  1  sticky, line_cnt >= WIN_LINES
- pick_valid  out  1  one-cycle pulse: local cell newly marked
- pick_num  out  5  map value of the picked cell; valid with pick_valid
- busy  out  1  state != IDLE

Behaviour:
- Reset, synchronous: all outputs 0, except remote_ready = 1 (state IDLE). Clears click_d, the latched coordinates and scan_idx. Reset mid-operation aborts the operation with no partial mark.
- click_d register; click edge = click & ~click_d, evaluated every cycle.
- States:
  - IDLE
    - If remote_valid: latch remote_num, set scan_idx = 0, go to SCAN. Remote has priority over a simultaneous click edge; that click is dropped.
    - Else if click edge & ptr_valid & my_turn: latch ptr_x and ptr_y, go to HIT.
    - Otherwise stay.
  - HIT
    - Outside window (x < WIN_X0, x >= WIN_X0 + 320, y < WIN_Y0, or y >= WIN_Y0 + 320): go to IDLE.
    - Else bx = (x - WIN_X0) >> CELL_SHIFT, by = (y - WIN_Y0) >> CELL_SHIFT, idx = bx + 5*by, evaluated at 10-bit width before the shift.
    - If circle[idx] is already set: go to IDLE.
    - Else go to MARK with src = local.
  - SCAN, one cell per cycle
    - If remote_num == 0: go to IDLE immediately.
    - If map[scan_idx] == remote_num: go to MARK with idx = scan_idx, src = remote.
    - Else if scan_idx == 24: go to IDLE; no match, no change.
    - Else scan_idx + 1.
    - A match on an already-marked cell goes to MARK; this is idempotent and raises no pick.
  - MARK
    - Set circle[idx].
    - If src = local and the bit was previously clear: pick_valid = 1 for exactly one cycle, pick_num = map[idx].
    - Go to EVAL.
  - EVAL: register line, line_cnt, and bingo |= (line_cnt_next >= WIN_LINES). Go to IDLE.
- Latency, measured from the clock edge that samples the click edge:
  - HIT at +1, MARK at +2.
  - circle and pick_valid visible after edge +3.
  - line, line_cnt, bingo visible after edge +4.
- Remote latency: match at cell k gives circle visible k+3 cycles after acceptance.
- Input handling while busy:
  - Click edges are ignored and not queued.
  - remote_valid must be held until remote_ready.
- my_turn and ptr_valid are sampled only at the click edge in IDLE.
- line/line_cnt update only in EVAL, so they lag circle by one cycle.
- bingo never clears except by rst.

Decomposition:
- Package bingo_pkg:
  - GRID, window origin/size constants, CELL_SHIFT
  - state enum {IDLE, HIT, SCAN, MARK, EVAL}
  - line index constants (ROW0..ROW4, COL0..COL4, DIAG, ANTI)
- Sub-module bingo_line_eval: purely combinational; 25-bit circle in, 12-bit line and 4-bit popcount out. Reused by the opponent-board logic.

Test Plan:
- Local hit: my_turn=1, map cell 7 = 13, click at (300,150) → idx = 2 + 5*1 = 7; after edge +3: circle = 0x80, pick_valid one cycle, pick_num = 13.
- Out of window and edges: clicks at (159,200), (480,200), (200,400) → no pick, circle unchanged. Click at (479,399) → idx 24 marked.
- Remote scan: map cell 20 = 9, remote_num = 9 handshake → circle[20] set 23 cycles after acceptance, no pick_valid. remote_num = 0 or 26 → no change, back in IDLE, remote_ready = 1.
- Priority and busy: remote_valid and click edge in the same cycle → only remote processed. Second click during SCAN → ignored. Click on an already-marked cell → no pick_valid.
- Lines: mark cells 0,6,12,18,24 then 20,21,22,23 → line[10] and line[4] set, line_cnt = 2. Complete 5 lines → bingo = 1 one cycle after the final circle update; stays 1.
- Reset mid-SCAN at scan_idx = 10: next cycle all outputs 0, remote_ready = 1, and the previously matching number is not marked.
